// File: rtl/instr_mem_wait.sv
// Loadable instruction memory with programmable wait states,
// valid/ready fetch handshakes, flush and address error flags.
module instr_mem_wait #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD = 32'hE1A00000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] PC,
  input  logic                  req_valid,
  output logic                  req_ready,
  output logic [DATA_WIDTH-1:0] Instruction,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  input  logic                  flush,
  output logic                  misaligned,
  output logic                  out_of_range,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WC_LOAD =
    (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state, state_nx;
  logic [3:0]      cnt, cnt_nx;
  logic [AW-1:0]   idx_q;
  logic            mis_q, oor_q;
  logic [AW-1:0]   cap_idx;
  logic            cap, cap_mis, cap_oor;
  logic            accept;
  logic            pc_mis, pc_oor, ld_oor;
  logic [DATA_WIDTH-1:0] instr_q;
  logic            mis_r, oor_r;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign pc_mis = |PC[1:0];
  assign pc_oor = |(PC >> (AW + 2));
  assign ld_oor = |(load_addr >> (AW + 2));

  assign req_ready = !flush &&
    (state == S_IDLE || (state == S_RESP && rsp_ready));
  assign accept = req_valid && req_ready;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cap      = 1'b0;
    cap_idx  = idx_q;
    cap_mis  = mis_q;
    cap_oor  = oor_q;
    if (flush) begin
      state_nx = S_IDLE;
    end else if (accept) begin
      if (WAIT_CYCLES == 0) begin
        state_nx = S_RESP;
        cap      = 1'b1;
        cap_idx  = PC[AW+1:2];
        cap_mis  = pc_mis;
        cap_oor  = pc_oor;
      end else begin
        state_nx = S_WAIT;
        cnt_nx   = WC_LOAD;
      end
    end else begin
      unique case (1'b1)
        (state == S_WAIT): begin
          if (cnt == 4'd0) begin
            state_nx = S_RESP;
            cap      = 1'b1;
          end else begin
            cnt_nx = cnt - 4'd1;
          end
        end
        (state == S_RESP): begin
          if (rsp_ready) state_nx = S_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      idx_q   <= '0;
      mis_q   <= 1'b0;
      oor_q   <= 1'b0;
      instr_q <= '0;
      mis_r   <= 1'b0;
      oor_r   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        idx_q <= PC[AW+1:2];
        mis_q <= pc_mis;
        oor_q <= pc_oor;
      end
      if (cap) begin
        instr_q <= (cap_mis || cap_oor) ? NOP_WORD : mem[cap_idx];
        mis_r   <= cap_mis;
        oor_r   <= cap_oor;
      end
    end
  end

  // array has no reset; a same-edge load is seen by the next capture
  always_ff @(posedge clk) begin
    if (load_en && !ld_oor) mem[load_addr[AW+1:2]] <= load_data;
  end

  assign rsp_valid    = (state == S_RESP);
  assign Instruction  = instr_q;
  assign misaligned   = mis_r;
  assign out_of_range = oor_r;

endmodule

// File: tb/tb_instr_mem_wait.sv
// Random + directed bench for instr_mem_wait, two instances
// (WAIT_CYCLES=2 at index 0, WAIT_CYCLES=0 at index 1).
module tb_instr_mem_wait;

  localparam int DEPTH = 256;
  localparam logic [31:0] NOP = 32'hE1A00000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc = '0;
  logic        req_valid = 1'b0;
  logic        rsp_ready = 1'b0;
  logic        flush = 1'b0;
  logic        load_en = 1'b0;
  logic [31:0] load_addr = '0;
  logic [31:0] load_data = '0;

  logic [1:0]  rr, rv, mo, oo;
  logic [31:0] ins [2];

  instr_mem_wait #(.WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .rst(rst), .PC(pc),
    .req_valid(req_valid), .req_ready(rr[0]),
    .Instruction(ins[0]), .rsp_valid(rv[0]),
    .rsp_ready(rsp_ready), .flush(flush),
    .misaligned(mo[0]), .out_of_range(oo[0]),
    .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data)
  );

  instr_mem_wait #(.WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .PC(pc),
    .req_valid(req_valid), .req_ready(rr[1]),
    .Instruction(ins[1]), .rsp_valid(rv[1]),
    .rsp_ready(rsp_ready), .flush(flush),
    .misaligned(mo[1]), .out_of_range(oo[1]),
    .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference: fetch in flight counts down edges to its capture
  logic [31:0] mmem [DEPTH];
  bit          m_inf [2];
  int          m_left [2];
  logic [31:0] m_pc [2];
  bit          m_rv [2];
  logic [31:0] m_word [2];
  bit          m_mis [2];
  bit          m_oor [2];

  function automatic int wc(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic bit m_ready(input int k);
    return !flush && !m_inf[k] && (!m_rv[k] || rsp_ready);
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_inf[k] = 0; m_left[k] = 0; m_pc[k] = '0;
      m_rv[k] = 0; m_word[k] = '0;
      m_mis[k] = 0; m_oor[k] = 0;
    end
  endtask

  task automatic m_capture(input int k, input logic [31:0] a);
    m_mis[k] = (a % 4) != 0;
    m_oor[k] = (a / 4) >= DEPTH;
    if (m_mis[k] || m_oor[k]) m_word[k] = NOP;
    else m_word[k] = mmem[a / 4];
    m_rv[k] = 1;
  endtask

  task automatic model_edge();
    bit acc;
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        m_inf[k] = 0; m_rv[k] = 0; m_word[k] = '0;
        m_mis[k] = 0; m_oor[k] = 0;
      end else begin
        acc = req_valid && m_ready(k);
        if (flush) begin
          m_inf[k] = 0;
          m_rv[k] = 0;
        end else begin
          if (m_rv[k] && rsp_ready) m_rv[k] = 0;
          if (m_inf[k]) begin
            m_left[k]--;
            if (m_left[k] == 0) begin
              m_inf[k] = 0;
              m_capture(k, m_pc[k]);
            end
          end
          if (acc) begin
            if (wc(k) == 0) m_capture(k, pc);
            else begin
              m_inf[k] = 1;
              m_left[k] = wc(k);
              m_pc[k] = pc;
            end
          end
        end
      end
    end
    if (load_en && (load_addr / 4) < DEPTH)
      mmem[load_addr / 4] = load_data;
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("req_ready[%0d]", k), rr[k], m_ready(k));
      check($sformatf("rsp_valid[%0d]", k), rv[k], m_rv[k]);
      check($sformatf("instr[%0d]", k), ins[k], m_word[k]);
      check($sformatf("misal[%0d]", k), mo[k], m_mis[k]);
      check($sformatf("oor[%0d]", k), oo[k], m_oor[k]);
    end
  endtask

  task automatic tick();
    #1;
    compare_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drain();
    req_valid = 0; flush = 0; load_en = 0; rsp_ready = 1;
    repeat (5) tick();
  endtask

  task automatic fetch2(input logic [31:0] a, output int n);
    pc = a; req_valid = 1; rsp_ready = 1;
    tick();
    req_valid = 0;
    n = 0;
    while (!rv[0] && n < 10) begin
      tick();
      n++;
    end
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    load_en = 1; load_addr = a; load_data = d;
    tick();
    load_en = 0;
  endtask

  logic [31:0] save;
  int n;

  initial begin
    #2;
    for (int k = 0; k < 2; k++) begin
      check("rst_valid", rv[k], 0);
      check("rst_instr", ins[k], 0);
      check("rst_mis", mo[k], 0);
      check("rst_oor", oo[k], 0);
    end
    m_reset();
    for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
    tick(); tick();
    rst = 1;
    tick();

    for (int i = 0; i < DEPTH; i++) load(i * 4, $urandom);

    load(0, 32'hE3A00B01);
    load(4, 32'hE4901200);
    fetch2(0, n);
    check("lat_pc0", n, 2);
    check("word_pc0", ins[0], 32'hE3A00B01);
    tick();
    fetch2(4, n);
    check("lat_pc4", n, 2);
    check("word_pc4", ins[0], 32'hE4901200);
    drain();

    req_valid = 1; rsp_ready = 1;
    for (int i = 0; i < 3; i++) begin
      pc = i * 4;
      #1 check("b2b_ready", rr[1], 1);
      tick();
      check("b2b_valid", rv[1], 1);
      check("b2b_word", ins[1], mmem[i]);
    end
    drain();

    fetch2(4, n);
    rsp_ready = 0; req_valid = 1; pc = 8;
    save = ins[0];
    repeat (4) begin
      tick();
      check("stall_instr", ins[0], save);
      check("stall_valid", rv[0], 1);
      check("stall_ready", rr[0], 0);
    end
    rsp_ready = 1;
    #1 check("stall_accept", rr[0], 1);
    tick();
    drain();

    pc = 8; req_valid = 1;
    tick();
    req_valid = 0;
    tick();
    flush = 1;
    tick();
    flush = 0;
    repeat (4) begin
      tick();
      check("flush_wait", rv[0], 0);
    end
    fetch2(0, n);
    check("flush_next", ins[0], mmem[0]);
    tick();
    pc = 4; req_valid = 1;
    tick();
    req_valid = 0; rsp_ready = 0;
    n = 0;
    while (!rv[0] && n < 10) begin tick(); n++; end
    check("flush_resp_pre", rv[0], 1);
    flush = 1;
    tick();
    check("flush_resp", rv[0], 0);
    drain();

    fetch2(6, n);
    check("mis_word", ins[0], NOP);
    check("mis_flag", {mo[0], oo[0]}, 2'b10);
    tick();
    fetch2(1024, n);
    check("oor_word", ins[0], NOP);
    check("oor_flag", {mo[0], oo[0]}, 2'b01);
    tick();
    fetch2(1026, n);
    check("both_word", ins[0], NOP);
    check("both_flag", {mo[0], oo[0]}, 2'b11);
    drain();

    load(8, 32'hAAAA0002);
    drain();
    pc = 8; req_valid = 1;
    tick();
    req_valid = 0;
    tick();
    load(8, 32'hBBBB0002);
    check("coll_valid", rv[0], 1);
    check("coll_old", ins[0], 32'hAAAA0002);
    tick();
    fetch2(8, n);
    check("coll_new", ins[0], 32'hBBBB0002);
    drain();

    pc = 0; req_valid = 1;
    tick();
    req_valid = 0;
    rst = 0;
    #1;
    m_reset();
    for (int k = 0; k < 2; k++) begin
      check("arst_valid", rv[k], 0);
      check("arst_instr", ins[k], 0);
    end
    tick();
    rst = 1;
    tick();
    fetch2(0, n);
    check("post_rst_lat", n, 2);
    check("post_rst_word", ins[0], mmem[0]);
    drain();

    repeat (1500) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) pc = $urandom_range(0, 4 * DEPTH - 1);
      else if (r == 1) pc = 4 * DEPTH + $urandom_range(0, 4000);
      else pc = 4 * $urandom_range(0, DEPTH - 1);
      req_valid = ($urandom_range(0, 9) < 7);
      rsp_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 11) == 0);
      load_en = ($urandom_range(0, 4) == 0);
      load_addr = $urandom_range(0, 4 * DEPTH + 64);
      load_data = $urandom;
      tick();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/instr_mem_wait.md
Name: instr_mem_wait

Overview:
Parametrised, synchronous instruction memory for the ARM pipeline fetch stage. It replaces the hard-coded combinational ROM with a loadable word array. A programmable wait-state count models slow memory. Fetch requests and responses use valid/ready handshakes, and the block supports flush on branch, misalignment detection and out-of-range detection.

Parameters:
DATA_WIDTH, 32, instruction word width
ADDR_WIDTH, 32, PC width (byte address)
DEPTH, 256, number of words in the array (power of two, >=4)
WAIT_CYCLES, 2, extra cycles per fetch (0..15)
NOP_WORD, 32'hE1A00000, word returned on an error response (MOV R0,R0)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
PC  in  ADDR_WIDTH  fetch byte address
req_valid  in  1  fetch request
req_ready  out  1  block accepts a request this cycle
Instruction  out  DATA_WIDTH  fetched word, held while rsp_valid
rsp_valid  out  1  Instruction valid
rsp_ready  in  1  downstream consumes the response (low = stall)
flush  in  1  abort the in-flight fetch (branch taken)
misaligned  out  1  qualifies rsp_valid: PC[1:0]!=0
out_of_range  out  1  qualifies rsp_valid: PC[ADDR_WIDTH-1:2] >= DEPTH
load_en  in  1  program-load write strobe
load_addr  in  ADDR_WIDTH  load byte address (bits [1:0] ignored)
load_data  in  DATA_WIDTH  load word

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0.
  - rsp_valid=0, Instruction=0, misaligned=0, out_of_range=0.
  - Array contents are not reset.
- req_ready = !flush && (state==IDLE || (state==RESP && rsp_ready)). It is combinational.
- Request accepted at edge E when req_valid && req_ready. PC, misaligned and out_of_range are latched at E.
- FSM, states IDLE, WAIT, RESP:
  - IDLE, accept: if WAIT_CYCLES==0, go to RESP and capture the word at E. Otherwise go to WAIT with counter=WAIT_CYCLES-1.
  - WAIT: if counter==0, go to RESP and capture the word. Otherwise decrement the counter.
  - RESP: rsp_valid=1. Instruction, misaligned and out_of_range are stable until the handshake.
    - rsp_ready && accept: same transition as IDLE accept (back-to-back, no bubble).
    - rsp_ready without accept: go to IDLE, rsp_valid=0.
    - !rsp_ready: hold.
- Latency: rsp_valid first high in the cycle after edge E+WAIT_CYCLES, where E is the accept edge. Throughput is one word per WAIT_CYCLES+1 cycles with rsp_ready held high.
- Word capture:
  - If misaligned or out_of_range, Instruction=NOP_WORD and the matching flag is 1.
  - Otherwise Instruction=mem[PC[log2(DEPTH)+1:2]]. Both flags are 0.
  - If both errors apply, both flags are 1.
- flush (synchronous, priority over everything but reset): state goes to IDLE and rsp_valid goes to 0 at the next edge. No request is accepted in a flush cycle. A flush in WAIT discards the fetch; a flush in RESP drops the unconsumed response.
- Load port:
  - load_en writes mem[load_addr word index] at the edge, in any state.
  - Out-of-range load addresses are ignored.
  - A load to the same word in the same cycle as capture returns the old data (read-before-write). A later capture sees the new data.
- Counter is 4 bits and never wraps: it is reloaded only on accept.

Test Plan:
- Reset mid-WAIT (WAIT_CYCLES=2): assert rst during WAIT -> rsp_valid=0 and Instruction=0 immediately (asynchronous). After release, the first accept behaves normally.
- Load and fetch: load mem[0]=32'hE3A00B01 and mem[1]=32'hE4901200. Fetch PC=0 with WAIT_CYCLES=2 -> rsp_valid rises 3 cycles after accept with Instruction=32'hE3A00B01. Repeat for PC=4 -> 32'hE4901200.
- Back-to-back, WAIT_CYCLES=0, rsp_ready=1, PC=0,4,8 on consecutive accepts -> three responses on three consecutive cycles, no bubbles, req_ready held at 1.
- Stall: rsp_ready=0 for 4 cycles in RESP -> Instruction, rsp_valid and flags unchanged and req_ready=0. When rsp_ready rises, the pending req_valid is accepted that cycle.
- Flush: flush during WAIT for PC=8 -> no response for PC=8. Next request PC=0 returns mem[0]. Flush during RESP -> rsp_valid=0 the next cycle.
- Errors, DEPTH=256:
  - PC=6 -> NOP_WORD, misaligned=1.
  - PC=1024 -> NOP_WORD, out_of_range=1.
  - PC=1026 -> both flags set.
  - Load/capture collision at word 2 -> old value returned, new value on the next fetch.
